// File: rtl/ifetch_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch stage.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Small prefetch FIFO of fetched {ir, pc} entries with synchronous flush.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) entries[wr_ptr] <= push_data;
  end

  // Flush beats any simultaneous push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_pipe.sv
// MIPS32 fetch stage: PC, synchronous-read instruction memory and a prefetch
// queue feeding decode over valid/ready, with a squashing redirect.
module ifetch_pipe
  import ifetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              QDEPTH     = 2,
  localparam int             AW         = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_npc,
  input  logic            imem_we,
  input  logic [AW-1:0]   imem_waddr,
  input  logic [31:0]     imem_wdata
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] pc_p0;
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [31:0]     ir_p1;

  fetch_entry_t    q_head;
  fetch_entry_t    q_push_data;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occ;

  assign pop  = !q_empty && out_ready;
  assign push = vld_p1 && !redirect_valid;
  // Occupancy counts the in-flight read as a slot already taken.
  assign occ   = {1'b0, q_count} + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign issue = !redirect_valid && !(q_full && !pop) && (occ < (CW+1)'(QDEPTH));

  // ---- p0 -> p1: memory read and tag capture ----
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
    if (issue) begin
      ir_p1 <= imem[pc_p0[AW+1:2]];
      pc_p1 <= pc_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0  <= RESET_PC_ALIGNED;
      vld_p1 <= 1'b0;
    end else if (redirect_valid) begin
      pc_p0  <= {redirect_pc[XLEN-1:2], 2'b00};
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) pc_p0 <= next_pc(pc_p0);
    end
  end

  // ---- p1 -> queue: push returned data unless squashed ----
  assign q_push_data = '{ir: ir_p1, pc: pc_p1};

  ifetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (q_push_data),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign out_valid = !q_empty;
  assign out_ir    = q_empty ? NOP_INSN : q_head.ir;
  assign out_pc    = q_empty ? RESET_PC : q_head.pc;
  assign out_npc   = next_pc(out_pc);

endmodule

// File: tb/tb_ifetch_pipe.sv
// Scoreboard bench for ifetch_pipe: expected fetch addresses are queued when
// stimulus is applied and compared against each decode handshake.
module tb_ifetch_pipe;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic [31:0] out_npc;
  logic        imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [31:0] imem_wdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb [$];

  ifetch_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_ir         (out_ir),
    .out_pc         (out_pc),
    .out_npc        (out_npc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_ir(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) & 32'h0000_03FF);
  endfunction

  task automatic expect_run(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // Accept n instructions, comparing each against the scoreboard head.
  task automatic consume(input int n, input string tag);
    int got = 0;
    int cyc = 0;
    logic [31:0] exp_pc;
    out_ready = 1'b1;
    while (got < n && cyc < 40) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, out_pc, 32'hDEAD_BEEF);
        end else begin
          exp_pc = sb.pop_front();
          check({tag, "_pc"}, out_pc, exp_pc);
          check({tag, "_ir"}, out_ir, model_ir(exp_pc));
          check({tag, "_npc"}, out_npc, exp_pc + 32'd4);
        end
        got++;
      end
      cyc++;
      @(posedge clk); #1;
      if (got == n) out_ready = 1'b0;
      else @(negedge clk);
    end
    if (got < n) begin
      check({tag, "_timeout"}, 32'(got), 32'(n));
      out_ready = 1'b0;
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = AW'(i);
      imem_wdata = 32'h1000_0000 + 32'(i);
    end
    @(negedge clk);
    imem_we = 1'b0;

    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ir", out_ir, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_npc", out_npc, 32'h4);

    // Start-up stream, then a 5-cycle stall on pc 0x8.
    expect_run(32'h0, 5);
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("valid_rise", {31'b0, out_valid}, 32'd1);
    consume(2, "start");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_pc", out_pc, 32'h8);
      check("stall_ir", out_ir, 32'h1000_0002);
    end
    consume(3, "resume");

    // Redirect with decode ready: squash, two bubbles, then target.
    expect_run(32'h100, 3);
    out_ready = 1'b1;
    redirect(32'h100);
    @(negedge clk);
    check("redir_k", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("redir_k1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("redir_k2", {31'b0, out_valid}, 32'd1);
    consume(3, "redir");

    // Redirect during a stall, unaligned target.
    expect_run(32'h100, 2);
    redirect(32'h103);
    @(negedge clk);
    check("stall_redir_sq", {31'b0, out_valid}, 32'd0);
    consume(2, "unalign");

    // Memory index wraps while the PC keeps counting.
    expect_run(32'hFFC, 3);
    redirect(32'hFFC);
    @(negedge clk);
    consume(3, "wrap");

    // Asynchronous reset pulse between edges mid-stream.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_ir", out_ir, 32'h0);
    expect_run(32'h0, 3);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    consume(3, "restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_pipe.md
Name: ifetch_pipe

Overview:
- Parametrised MIPS32 instruction-fetch stage. Successor to the single-register fetch block.
- Holds the PC and a synchronous-read instruction memory, plus a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Supports a branch/jump redirect from EX/MEM that squashes all in-flight and queued fetches. Sits between the PC-select logic and the IF/ID boundary.

Parameters:
- XLEN, 32, datapath and PC width.
- IMEM_DEPTH, 1024, instruction memory words (power of two); AW = log2(IMEM_DEPTH).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- QDEPTH, 2, prefetch queue entries (power of two, at least 2).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, reset, asynchronous assert, active-low.
- redirect_valid, in, 1, take branch/jump target this cycle.
- redirect_pc, in, XLEN, target byte address.
- out_ready, in, 1, decode accepts the head instruction.
- out_valid, out, 1, head instruction valid.
- out_ir, out, 32, instruction word.
- out_pc, out, XLEN, address of out_ir.
- out_npc, out, XLEN, out_pc + 4.
- imem_we, in, 1, load-port write enable (bench and boot loader).
- imem_waddr, in, AW, word address for load port.
- imem_wdata, in, 32, load-port data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - PC = RESET_PC.
  - Queue emptied; in-flight flag = 0.
  - out_valid = 0; out_ir = NOP (32'h0); out_pc = RESET_PC; out_npc = RESET_PC + 4.
  - Memory contents are not cleared.
  - A reset asserted mid-operation discards everything, with no partial outputs.
- Addressing:
  - Word index = PC[AW+1:2]; PC bits [1:0] are ignored and forced to 0 when loaded.
  - Upper PC bits above AW+1 wrap the memory modulo IMEM_DEPTH.
  - The PC itself counts the full XLEN and wraps naturally at 2^XLEN.
- Memory timing:
  - Synchronous read: address issued in cycle t, data valid in cycle t+1.
  - That data is pushed into the queue at the edge ending cycle t+1.
  - A load-port write to the same word in the same cycle as a read returns the old data.
- Issue rule:
  - A fetch issues in a cycle when (queue count + in-flight − pop_this_cycle) < QDEPTH.
  - On issue: in-flight = 1, tagged with PC; PC <= PC + 4.
  - With QDEPTH = 2 and out_ready held high, throughput is one instruction per cycle.
- Output:
  - out_valid = queue not empty. out_ir, out_pc and out_npc come from the queue head.
  - Pop occurs when out_valid && out_ready.
  - Outputs are stable while out_valid && !out_ready (no change, no loss).
- Redirect (redirect_valid sampled at edge k):
  - PC <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Queue flushed; the in-flight response is killed and never pushed.
  - out_valid = 0 after edge k.
  - Target fetch issues in cycle k+1; out_valid = 1 with out_pc = target after edge k+2.
- Priority: reset > redirect > pop/push > issue.
  - Redirect overrides a simultaneous pop; a pop that handshakes in the redirect cycle still counts as consumed by decode.
  - Redirect overrides a simultaneous stall (out_ready = 0).
- Full queue: no issue, PC holds.
- Empty queue with out_ready high: nothing popped, out_valid stays 0.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- Queue count width = log2(QDEPTH)+1. Pointers wrap modulo QDEPTH.

Decomposition:
- Package ifetch_pkg:
  - XLEN and PC_STEP (4).
  - NOP_INSN (32'h0).
  - fetch_entry_t struct {ir, pc}.
  - Helper function next_pc(pc).
- Sub-module ifetch_queue: parametrised FIFO of fetch_entry_t with push, pop, synchronous flush, count, full and empty.
- Memory array and PC/issue logic stay in ifetch_pipe.

Test Plan:
- Preload mem[i] = 32'h1000_0000 + i via the load port; release reset with out_ready = 1.
  - Required: out_valid rises within 2 cycles.
  - Handshakes give out_pc 0x0, 0x4, 0x8 with out_ir 0x10000000, 0x10000001, 0x10000002, one per cycle.
  - out_npc = out_pc + 4 throughout.
- Hold out_ready = 0 for 5 cycles after pc 0x8 is presented.
  - Required: outputs frozen at pc 0x8 / ir 0x10000002.
  - After release, the sequence continues 0xC, 0x10 with no skip or duplicate.
- Redirect to 0x100 at edge k.
  - Required: out_valid = 0 after k.
  - After k+2: out_pc = 0x100, ir = 0x10000040, npc = 0x104.
  - No pre-redirect instruction appears after k.
- Redirect to 0x103 while out_ready = 0.
  - Required: out_pc = 0x100 (low bits dropped); redirect wins over the stall.
- Redirect to 0xFFC (IMEM_DEPTH = 1024).
  - Required: out_pc 0xFFC ir 0x100003FF, then out_pc 0x1000 ir 0x10000000 (memory wrap).
- Assert rst_n low mid-stream for 1 cycle, asynchronously between edges.
  - Required: out_valid = 0 immediately; restart from pc 0x0 / ir 0x10000000; memory contents retained.
